// File: rtl/mmio_out_fifo.sv
// Memory-mapped output FIFO on the CPU store bus: stores to DATA_ADDR are queued
// and drained over valid/ready; STATUS_ADDR gives a status read and control write.
module mmio_out_fifo #(
   parameter int          n           = 32,
   parameter int          DEPTH       = 8,
   parameter logic [n-1:0] DATA_ADDR   = 32'h0000_0054,
   parameter logic [n-1:0] STATUS_ADDR = 32'h0000_0058
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         memwrite,
   input  logic [n-1:0] dataadr,
   input  logic [n-1:0] writedata,
   output logic [n-1:0] readdata,
   output logic         out_valid,
   output logic [n-1:0] out_data,
   input  logic         out_ready,
   output logic         overflow,
   output logic [15:0]  push_count
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [n-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [7:0]    count8;

   logic push_req;
   logic ctrl_wr;
   logic pop;
   logic full;
   logic empty;
   logic push_ok;
   logic flush;

   assign push_req  = memwrite && (dataadr == DATA_ADDR);
   assign ctrl_wr   = memwrite && (dataadr == STATUS_ADDR);
   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok   = push_req && (!full || pop);
   assign flush     = ctrl_wr && writedata[1];
   assign out_data  = mem[rd_ptr];
   assign count8    = 8'(count);

   always_comb begin
      readdata = '0;
      if (dataadr == STATUS_ADDR)
         readdata = {16'h0000, count8, 5'b00000, overflow, full, empty};
   end

   always_ff @(posedge clk) begin
      if (!reset && push_ok)
         mem[wr_ptr] <= writedata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         push_count <= '0;
      end else begin
         // Flush wins over a same-cycle pop; a push cannot coincide with a control write.
         if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_count <= '0;
         end else begin
            if (push_ok) begin
               wr_ptr     <= wr_ptr + 1'b1;
               push_count <= push_count + 16'd1;
            end
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
         if (push_req && !push_ok)
            overflow <= 1'b1;
         else if (ctrl_wr && writedata[0])
            overflow <= 1'b0;
      end
   end

endmodule
